// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives the PC into combinational program memory and
// hands fetched words to decode through a one-entry valid/ready register.
module fetch_sequencer #(
  parameter int PC_WIDTH          = 8,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int PROG_END          = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         halt_req,
  input  logic                         jump_valid,
  input  logic [PC_WIDTH-1:0]          jump_addr,
  output logic [PC_WIDTH-1:0]          pc,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_instruction,
  output logic [INSTRUCTION_WIDTH-1:0] ir,
  output logic [PC_WIDTH-1:0]          ir_pc,
  output logic                         ir_valid,
  input  logic                         ir_ready,
  output logic                         halted,
  output logic                         fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  // One extra bit so targets beyond PROG_END are detectable even
  // when PROG_END is the top of the PC range.
  localparam logic [PC_WIDTH:0]   END_EXT = (PC_WIDTH+1)'(PROG_END);
  localparam logic [PC_WIDTH-1:0] END_PC  = PC_WIDTH'(PROG_END);

  logic [1:0]          state;
  logic [1:0]          state_nx;
  logic [PC_WIDTH-1:0] pc_nx;
  logic                ir_valid_nx;
  logic                fault_nx;
  logic                capture;
  logic                accept;
  logic                slot_free;
  logic                jump_oob;

  assign accept    = ir_valid & ir_ready;
  assign slot_free = ~ir_valid | ir_ready;
  assign jump_oob  = {1'b0, jump_addr} > END_EXT;

  // Next-state: jump outranks halt_req, halt_req outranks fetch.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    ir_valid_nx = accept ? 1'b0 : ir_valid;
    fault_nx    = fault;
    capture     = 1'b0;
    if (jump_valid) begin
      ir_valid_nx = 1'b0;
      if (jump_oob) begin
        fault_nx = 1'b1;
        state_nx = S_HALT;
      end else begin
        pc_nx = jump_addr;
        if (state == S_DRAIN ||
            (state == S_FETCH && halt_req))
          state_nx = S_HALT;
      end
    end else begin
      unique case (state)
        S_FETCH: begin
          if (halt_req) begin
            state_nx = slot_free ? S_HALT : S_DRAIN;
          end else if (slot_free) begin
            capture     = 1'b1;
            ir_valid_nx = 1'b1;
            pc_nx = (pc == END_PC) ? '0
                  : pc + PC_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (accept) state_nx = S_HALT;
        end
        default: begin
          if (start && !fault) state_nx = S_FETCH;
        end
      endcase
    end
  end

  // Control registers: state, PC, valid, halted and sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b1;
      fault    <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      ir_valid <= ir_valid_nx;
      halted   <= (state_nx == S_IDLE) ||
                  (state_nx == S_HALT);
      fault    <= fault_nx;
    end
  end

  // Instruction register loads only on a fetch, so it holds on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir    <= '0;
      ir_pc <= '0;
    end else if (capture) begin
      ir    <= mem_instruction;
      ir_pc <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table vectors, directed corner sequences and a
// random run against a reference model, on PROG_END=255 and PROG_END=50.
module tb_fetch_sequencer;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, jump_valid, ir_ready;
  logic [7:0]  jump_addr;
  logic [7:0]  pc0, ir_pc0, pc1, ir_pc1;
  logic [31:0] mem0, mem1, ir0, ir1;
  logic        v0, h0, f0, v1, h1, f1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem0 = 32'h100 + {24'h0, pc0};
  assign mem1 = 32'h100 + {24'h0, pc1};

  fetch_sequencer u_d0 (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .pc(pc0),
    .mem_instruction(mem0), .ir(ir0), .ir_pc(ir_pc0),
    .ir_valid(v0), .ir_ready(ir_ready), .halted(h0), .fault(f0)
  );

  fetch_sequencer #(.PROG_END(50)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .pc(pc1),
    .mem_instruction(mem1), .ir(ir1), .ir_pc(ir_pc1),
    .ir_valid(v1), .ir_ready(ir_ready), .halted(h1), .fault(f1)
  );

  // Reference model: st 0=idle 1=run 2=drain 3=stopped
  typedef struct {
    int st;
    int pc;
    int ir_pc;
    bit v;
    bit fault;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t step(mdl_t m, int pe);
    mdl_t n = m;
    bit acc  = m.v && ir_ready;
    bit free = !m.v || ir_ready;
    if (rst) begin
      n = '{0, 0, 0, L, L};
      return n;
    end
    if (acc) n.v = L;
    if (jump_valid) begin
      n.v = L;
      if (int'(jump_addr) > pe) begin
        n.fault = H;
        n.st = 3;
      end else begin
        n.pc = int'(jump_addr);
        if (m.st == 2 || (m.st == 1 && halt_req)) n.st = 3;
      end
      return n;
    end
    case (m.st)
      1: begin
        if (halt_req) n.st = free ? 3 : 2;
        else if (free) begin
          n.ir_pc = m.pc;
          n.v = H;
          n.pc = (m.pc + 1) % (pe + 1);
        end
      end
      2: if (acc) n.st = 3;
      default: if (start && !m.fault) n.st = 1;
    endcase
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("m0_pc", {24'h0, pc0}, 32'(m0.pc));
    chk("m0_valid", {31'h0, v0}, {31'h0, m0.v});
    chk("m0_halted", {31'h0, h0}, {31'h0, (m0.st == 0 || m0.st == 3)});
    chk("m0_fault", {31'h0, f0}, {31'h0, m0.fault});
    if (m0.v) begin
      chk("m0_ir_pc", {24'h0, ir_pc0}, 32'(m0.ir_pc));
      chk("m0_ir", ir0, 32'h100 + 32'(m0.ir_pc));
    end
    chk("m1_pc", {24'h0, pc1}, 32'(m1.pc));
    chk("m1_valid", {31'h0, v1}, {31'h0, m1.v});
    chk("m1_halted", {31'h0, h1}, {31'h0, (m1.st == 0 || m1.st == 3)});
    chk("m1_fault", {31'h0, f1}, {31'h0, m1.fault});
    if (m1.v) begin
      chk("m1_ir_pc", {24'h0, ir_pc1}, 32'(m1.ir_pc));
      chk("m1_ir", ir1, 32'h100 + 32'(m1.ir_pc));
    end
  endtask

  task automatic cycle();
    check_model();
    m0 = step(m0, 255);
    m1 = step(m1, 50);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rst = L; start = L; halt_req = L;
    jump_valid = L; jump_addr = 8'h00; ir_ready = L;
  endtask

  task automatic do_reset();
    clear_in();
    rst = H;
    @(posedge clk);
    #1;
    rst = L;
    m0 = '{0, 0, 0, L, L};
    m1 = '{0, 0, 0, L, L};
  endtask

  typedef struct {
    bit         st;
    bit         hr;
    bit         jv;
    logic [7:0] ja;
    bit         rdy;
    logic [7:0] e_pc;
    bit         e_v;
    logic [7:0] e_irpc;
    bit         e_h;
  } vec_t;

  vec_t tbl [21];
  logic [7:0] wrap_exp [4];

  initial begin
    tbl[0]  = '{H, L, L, 8'h00, H, 8'h00, L, 8'h00, H};
    tbl[1]  = '{L, L, L, 8'h00, H, 8'h00, L, 8'h00, L};
    tbl[2]  = '{L, L, L, 8'h00, H, 8'h01, H, 8'h00, L};
    tbl[3]  = '{L, L, L, 8'h00, H, 8'h02, H, 8'h01, L};
    tbl[4]  = '{L, L, L, 8'h00, H, 8'h03, H, 8'h02, L};
    tbl[5]  = '{L, L, L, 8'h00, H, 8'h04, H, 8'h03, L};
    tbl[6]  = '{L, L, L, 8'h00, H, 8'h05, H, 8'h04, L};
    tbl[7]  = '{L, L, L, 8'h00, L, 8'h06, H, 8'h05, L};
    tbl[8]  = '{L, L, L, 8'h00, L, 8'h06, H, 8'h05, L};
    tbl[9]  = '{L, L, L, 8'h00, L, 8'h06, H, 8'h05, L};
    tbl[10] = '{L, L, L, 8'h00, H, 8'h06, H, 8'h05, L};
    tbl[11] = '{L, L, L, 8'h00, H, 8'h07, H, 8'h06, L};
    tbl[12] = '{L, L, H, 8'h40, L, 8'h08, H, 8'h07, L};
    tbl[13] = '{L, L, L, 8'h00, L, 8'h40, L, 8'h07, L};
    tbl[14] = '{L, L, L, 8'h00, H, 8'h41, H, 8'h40, L};
    tbl[15] = '{L, H, L, 8'h00, L, 8'h42, H, 8'h41, L};
    tbl[16] = '{L, L, L, 8'h00, L, 8'h42, H, 8'h41, L};
    tbl[17] = '{L, L, L, 8'h00, H, 8'h42, H, 8'h41, L};
    tbl[18] = '{H, L, L, 8'h00, L, 8'h42, L, 8'h41, H};
    tbl[19] = '{L, L, L, 8'h00, H, 8'h42, L, 8'h41, L};
    tbl[20] = '{L, L, L, 8'h00, H, 8'h43, H, 8'h42, L};
    wrap_exp[0] = 8'hFE;
    wrap_exp[1] = 8'hFF;
    wrap_exp[2] = 8'h00;
    wrap_exp[3] = 8'h01;

    do_reset();
    chk("rst_pc", {24'h0, pc0}, 32'h0);
    chk("rst_ir", ir0, 32'h0);
    chk("rst_ir_pc", {24'h0, ir_pc0}, 32'h0);
    chk("rst_valid", {31'h0, v0}, 32'h0);
    chk("rst_halted", {31'h0, h0}, 32'h1);
    chk("rst_fault", {31'h0, f0}, 32'h0);

    // Table: start, stream, stall, jump flush, drain, restart
    for (int i = 0; i < 21; i++) begin
      start      = tbl[i].st;
      halt_req   = tbl[i].hr;
      jump_valid = tbl[i].jv;
      jump_addr  = tbl[i].ja;
      ir_ready   = tbl[i].rdy;
      chk($sformatf("tbl%0d_pc", i), {24'h0, pc0}, {24'h0, tbl[i].e_pc});
      chk($sformatf("tbl%0d_valid", i), {31'h0, v0}, {31'h0, tbl[i].e_v});
      chk($sformatf("tbl%0d_halted", i), {31'h0, h0}, {31'h0, tbl[i].e_h});
      if (tbl[i].e_v) begin
        chk($sformatf("tbl%0d_ir_pc", i), {24'h0, ir_pc0},
            {24'h0, tbl[i].e_irpc});
        chk($sformatf("tbl%0d_ir", i), ir0,
            32'h100 + {24'h0, tbl[i].e_irpc});
      end
      cycle();
    end

    // Wrap from 0xFE on the full-range instance
    do_reset();
    jump_valid = H;
    jump_addr  = 8'hFE;
    cycle();
    clear_in();
    chk("wrap_idle_pc", {24'h0, pc0}, 32'hFE);
    chk("wrap_idle_halted", {31'h0, h0}, 32'h1);
    start = H;
    cycle();
    start = L;
    ir_ready = H;
    chk("wrap_fetch_pc", {24'h0, pc0}, 32'hFE);
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap%0d_valid", i), {31'h0, v0}, 32'h1);
      chk($sformatf("wrap%0d_ir_pc", i), {24'h0, ir_pc0},
          {24'h0, wrap_exp[i]});
      cycle();
    end

    // Out-of-range jump on the PROG_END=50 instance
    do_reset();
    start = H;
    cycle();
    start = L;
    ir_ready = H;
    cycle();
    cycle();
    jump_valid = H;
    jump_addr  = 8'd60;
    cycle();
    jump_valid = L;
    chk("oob_fault", {31'h0, f1}, 32'h1);
    chk("oob_halted", {31'h0, h1}, 32'h1);
    chk("oob_valid", {31'h0, v1}, 32'h0);
    chk("oob_pc", {24'h0, pc1}, 32'h2);
    start = H;
    cycle();
    start = L;
    cycle();
    chk("oob_start_ignored", {31'h0, h1}, 32'h1);
    chk("oob_start_pc", {24'h0, pc1}, 32'h2);
    rst = H;
    cycle();
    rst = L;
    chk("oob_rst_fault", {31'h0, f1}, 32'h0);
    chk("oob_rst_halted", {31'h0, h1}, 32'h1);
    chk("oob_rst_pc", {24'h0, pc1}, 32'h0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 9) == 0);
      halt_req   = ($urandom_range(0, 19) == 0);
      jump_valid = ($urandom_range(0, 19) == 0);
      jump_addr  = ($urandom_range(0, 1) == 1) ?
                   8'($urandom_range(0, 63)) :
                   8'($urandom_range(0, 255));
      ir_ready   = ($urandom_range(0, 9) < 7);
      cycle();
    end
    clear_in();
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the program counter into the combinational program memory (256 words) and presents fetched instructions to the decode stage through a one-entry valid/ready output register. It owns the PC, jump redirection, stall on decode back-pressure, and start/halt control. It sits between the program memory (`pc` out, instruction in) and the CPU decode/execute stage.

## Interface
- PC_WIDTH, 8, program-counter width; the memory holds 2^PC_WIDTH words.
- INSTRUCTION_WIDTH, 32, instruction word width.
- PROG_END, 255, last valid program address. Sequential fetch wraps from PROG_END to 0.

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins or resumes fetching from the current `pc`.
- halt_req  in  1  single-cycle pulse; stops fetching after the pending instruction drains.
- jump_valid  in  1  redirect request.
- jump_addr  in  PC_WIDTH  redirect target.
- pc  out  PC_WIDTH  address to program memory.
- mem_instruction  in  INSTRUCTION_WIDTH  memory data at `pc`, same-cycle combinational.
- ir  out  INSTRUCTION_WIDTH  fetched instruction.
- ir_pc  out  PC_WIDTH  address `ir` was fetched from.
- ir_valid  out  1  `ir` holds an unconsumed instruction.
- ir_ready  in  1  decode accepts `ir` this cycle.
- halted  out  1  high in IDLE and HALT.
- fault  out  1  sticky flag: a jump targeted an address > PROG_END.

## Operation
- States:
  - IDLE: post-reset.
  - FETCH: issuing.
  - DRAIN: halt requested while `ir_valid`=1.
  - HALT: stopped.
- Accept event: `ir_valid & ir_ready`. An accept is honoured in every state.
- Slot free: `!ir_valid | ir_ready`.
- Transitions:
  - IDLE/HALT -> FETCH on `start` with `fault`=0. `start` is ignored while `fault`=1.
  - FETCH -> HALT on `halt_req` if the slot is free after this cycle; otherwise FETCH -> DRAIN.
  - DRAIN -> HALT on accept.
  - Any state -> HALT on an out-of-range jump.
- Priority within a cycle: rst > jump_valid > halt_req > fetch.
- Fetch, in FETCH only, when the slot is free and there is no jump and no halt_req:
  - `ir` <= `mem_instruction`, `ir_pc` <= `pc`, `ir_valid` <= 1.
  - `pc` <= (`pc` == PROG_END) ? 0 : `pc`+1.
- Stall: in FETCH with the slot not free, `pc`, `ir`, `ir_pc` and `ir_valid` hold unchanged.
- Jump with `jump_addr` <= PROG_END, any state:
  - `pc` <= `jump_addr`; no capture that cycle.
  - `ir_valid` <= 0 (flush); a same-cycle accept still counts as consumed.
  - State is unchanged, except DRAIN -> HALT.
- Jump with `jump_addr` > PROG_END:
  - `fault` <= 1, `ir_valid` <= 0, state -> HALT, `pc` unchanged.
- halt_req in IDLE/HALT: no effect. start in FETCH/DRAIN: no effect.
- Simultaneous jump_valid and halt_req in FETCH: `pc` <= `jump_addr`, flush, state -> HALT.

## Timing
- Reset values (synchronous): state IDLE, `pc`=0, `ir`=0, `ir_pc`=0, `ir_valid`=0, `halted`=1, `fault`=0.
- Reset asserted mid-operation overrides every other input in that cycle.
- `halted` and `ir_valid` are registered, not combinational from inputs.
- `pc`, `ir`, `ir_pc`, `ir_valid`, `fault` are registers.
- Start latency:
  - `start` in cycle 0 gives FETCH in cycle 1 with `pc`=P.
  - Cycle 2: `ir_valid`=1, `ir`=mem[P].
- Throughput: one instruction per cycle while `ir_ready`=1.
- Jump latency:
  - `jump_valid` in cycle N gives `pc`=A in N+1.
  - `ir`=mem[A] is valid in N+2.
- `ir`/`ir_pc` must not change while `ir_valid`=1 and `ir_ready`=0.

## Test plan
- Reset, `start` at cycle 0, `ir_ready`=1, mem[i]=i+0x100 -> `ir_valid` from cycle 2, `ir`=0x100,0x101,0x102… on consecutive cycles, `ir_pc`=0,1,2…
- `ir_ready` low 3 cycles with `ir_pc`=5 -> `ir`, `ir_pc`, `pc`=6 frozen for 3 cycles; resume with `ir_pc`=6 the cycle after `ir_ready` rises.
- `jump_valid`, `jump_addr`=0x40 while `ir_pc`=7 and `ir_ready`=0 -> `ir_valid`=0 next cycle, `pc`=0x40, then `ir_pc`=0x40 valid; instruction at 7 never accepted.
- Run from `pc`=0xFE with PROG_END=255 -> `ir_pc` sequence 0xFE, 0xFF, 0x00, 0x01.
- `halt_req` with `ir_valid`=1, `ir_ready`=0 -> DRAIN, `halted`=0; `ir_ready`=1 one cycle -> HALT, `halted`=1, `ir_valid`=0; `start` -> fetching resumes at next sequential `pc`.
- PROG_END=50, `jump_addr`=60 -> `fault`=1, `halted`=1, `ir_valid`=0; subsequent `start` ignored; `rst` clears `fault` and returns to IDLE with `pc`=0.
